// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Purpose  : Shared constants and state encoding for the PWM output stage
// Revision : 1.0
// ============================================================================
package pwm_pkg;

    localparam int c_RATIO_W = 8;

    // Last value of the period counter; a period is 0..254, i.e. 255 ticks
    localparam logic [c_RATIO_W-1:0] PWM_PERIOD_MAX = 8'd254;

    typedef logic [1:0] pwm_state_t;

    localparam pwm_state_t c_ST_OFF  = 2'd0;
    localparam pwm_state_t c_ST_RUN  = 2'd1;
    localparam pwm_state_t c_ST_DEAD = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pwm_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : pwm_tick_gen
// Purpose  : CLK_DIV prescaler producing a single-cycle PWM tick
// Revision : 1.0
// ============================================================================
module pwm_tick_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic i_count_en,
    output logic o_tick
);

    localparam logic [15:0] c_DIV_LAST = 16'(CLK_DIV - 1);

    logic [15:0] r_presc;

    // Held at zero while idle so a fresh start always gets a full first tick
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (!i_count_en || (r_presc == c_DIV_LAST)) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 16'd1;
        end
    end

    assign o_tick = i_count_en && (r_presc == c_DIV_LAST);

endmodule
`default_nettype wire

// File: rtl/pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : pwm_driver
// Purpose  : 255-tick PWM output stage with period-aligned updates and
//            H-bridge dead-time before direction reversal
// Revision : 1.0
// ============================================================================
module pwm_driver
    import pwm_pkg::*;
#(
    parameter int CLK_DIV      = 16,
    parameter int DEAD_PERIODS = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pwm_enable,
    input  logic       pwm_update,
    input  logic [7:0] pwm_ratio,
    input  logic       pwm_direction,
    output logic       pwm_done,
    output logic       pwm_out,
    output logic       dir_out,
    output logic       pwm_busy
);

    localparam logic [7:0] c_DEAD_INIT = 8'(DEAD_PERIODS);
    localparam bit         c_HAS_DEAD  = (DEAD_PERIODS != 0);

    pwm_state_t           r_state;
    logic [c_RATIO_W-1:0] r_cnt;
    logic [c_RATIO_W-1:0] r_ratio_act;
    logic                 r_dir_act;
    logic [c_RATIO_W-1:0] r_shadow_ratio;
    logic                 r_shadow_dir;
    logic                 r_pending;
    logic [7:0]           r_dead_cnt;
    logic                 r_pwm_out;
    logic                 r_done;

    pwm_state_t           w_state_nxt;
    logic [c_RATIO_W-1:0] w_cnt_nxt;
    logic [c_RATIO_W-1:0] w_ratio_nxt;
    logic                 w_dir_nxt;
    logic [7:0]           w_dead_nxt;
    logic                 w_pending_nxt;
    logic                 w_apply;
    logic                 w_take;
    logic                 w_count_en;
    logic                 w_tick;
    logic                 w_boundary;
    logic                 w_req_pend;
    logic [c_RATIO_W-1:0] w_req_ratio;
    logic                 w_req_dir;

    assign w_count_en = pwm_enable && (r_state != c_ST_OFF);

    pwm_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clock      (clock),
        .reset      (reset),
        .i_count_en (w_count_en),
        .o_tick     (w_tick)
    );

    assign w_boundary = w_tick && (r_cnt == PWM_PERIOD_MAX);

    // An update landing on the boundary edge bypasses the shadow register
    assign w_req_pend  = r_pending | pwm_update;
    assign w_req_ratio = pwm_update ? pwm_ratio     : r_shadow_ratio;
    assign w_req_dir   = pwm_update ? pwm_direction : r_shadow_dir;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_ratio_nxt   = r_ratio_act;
        w_dir_nxt     = r_dir_act;
        w_dead_nxt    = r_dead_cnt;
        w_pending_nxt = r_pending | pwm_update;
        w_apply       = 1'b0;
        w_take        = 1'b0;

        case (r_state)
            c_ST_OFF: begin
                w_cnt_nxt = '0;
                if (r_pending) begin
                    w_ratio_nxt   = r_shadow_ratio;
                    w_dir_nxt     = r_shadow_dir;
                    w_apply       = 1'b1;
                    w_pending_nxt = pwm_update;
                end
                if (pwm_enable) begin
                    w_state_nxt = c_ST_RUN;
                end
            end

            c_ST_RUN, c_ST_DEAD: begin
                if (!pwm_enable) begin
                    w_state_nxt = c_ST_OFF;
                    w_cnt_nxt   = '0;
                    w_dead_nxt  = '0;
                end else begin
                    if (w_tick) begin
                        w_cnt_nxt = w_boundary ? '0 : r_cnt + 8'd1;
                    end
                    if (w_boundary && (r_state == c_ST_RUN) && w_req_pend) begin
                        if (c_HAS_DEAD && (w_req_dir != r_dir_act)) begin
                            w_state_nxt = c_ST_DEAD;
                            w_dead_nxt  = c_DEAD_INIT;
                        end else begin
                            w_take = 1'b1;
                        end
                    end
                    // Dead-time runs to completion even if the final request no longer reverses
                    if (w_boundary && (r_state == c_ST_DEAD)) begin
                        if (r_dead_cnt <= 8'd1) begin
                            w_take      = 1'b1;
                            w_state_nxt = c_ST_RUN;
                            w_dead_nxt  = '0;
                        end else begin
                            w_dead_nxt = r_dead_cnt - 8'd1;
                        end
                    end
                    if (w_take) begin
                        w_ratio_nxt   = w_req_ratio;
                        w_dir_nxt     = w_req_dir;
                        w_apply       = 1'b1;
                        w_pending_nxt = 1'b0;
                    end
                end
            end

            default: begin
                w_state_nxt = c_ST_OFF;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= c_ST_OFF;
            r_cnt          <= '0;
            r_ratio_act    <= '0;
            r_dir_act      <= 1'b0;
            r_shadow_ratio <= '0;
            r_shadow_dir   <= 1'b0;
            r_pending      <= 1'b0;
            r_dead_cnt     <= '0;
            r_pwm_out      <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ratio_act <= w_ratio_nxt;
            r_dir_act   <= w_dir_nxt;
            r_pending   <= w_pending_nxt;
            r_dead_cnt  <= w_dead_nxt;
            if (pwm_update) begin
                r_shadow_ratio <= pwm_ratio;
                r_shadow_dir   <= pwm_direction;
            end
            // Computed from next-state values so the waveform tracks the counter it is registered with
            r_pwm_out <= (w_state_nxt == c_ST_RUN) && (w_cnt_nxt < w_ratio_nxt);
            r_done    <= w_apply;
        end
    end

    assign pwm_out  = r_pwm_out;
    assign dir_out  = r_dir_act;
    assign pwm_done = r_done;
    assign pwm_busy = r_pending | (r_state == c_ST_DEAD);

endmodule
`default_nettype wire

// File: tb/tb_pwm_driver.sv
`default_nettype none
// Scoreboard bench for pwm_driver: every pwm_done pulse is matched against a
// queued expectation (cycle and direction); waveforms are measured directly.
module tb_pwm_driver;

    localparam int c_PER_A = 255;
    localparam int c_PER_B = 3 * 255;

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    logic       a_enable = 1'b0, a_update = 1'b0, a_dir = 1'b0;
    logic [7:0] a_ratio = 8'd0;
    logic       a_done, a_out, a_dir_out, a_busy;

    logic       b_enable = 1'b0, b_update = 1'b0, b_dir = 1'b0;
    logic [7:0] b_ratio = 8'd0;
    logic       b_done, b_out, b_dir_out, b_busy;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;
    int e_a      = 0;

    typedef struct {
        int   cyc;
        logic dir;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    pwm_driver #(.CLK_DIV(1), .DEAD_PERIODS(2)) u_dut_a (
        .clock(clock), .reset(reset),
        .pwm_enable(a_enable), .pwm_update(a_update),
        .pwm_ratio(a_ratio), .pwm_direction(a_dir),
        .pwm_done(a_done), .pwm_out(a_out),
        .dir_out(a_dir_out), .pwm_busy(a_busy)
    );

    pwm_driver #(.CLK_DIV(3), .DEAD_PERIODS(0)) u_dut_b (
        .clock(clock), .reset(reset),
        .pwm_enable(b_enable), .pwm_update(b_update),
        .pwm_ratio(b_ratio), .pwm_direction(b_dir),
        .pwm_done(b_done), .pwm_out(b_out),
        .dir_out(b_dir_out), .pwm_busy(b_busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per pwm_done pulse of instance A
    always @(negedge clock) begin
        if (a_done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got pulse at cycle %0d, expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("done_cycle", cyc, mon_e.cyc);
                check("done_dir", int'(a_dir_out), int'(mon_e.dir));
            end
        end
    end

    function automatic int next_boundary(input int u, input int e, input int per);
        int k;
        k = (u - e + per - 1) / per;
        if (k < 1) k = 1;
        return e + k * per;
    endfunction

    task automatic wait_cyc(input int n);
        @(negedge clock);
        while (cyc < n) @(negedge clock);
    endtask

    task automatic measure(input bit use_b, input int n, output int highs, output int first_low);
        logic v;
        highs     = 0;
        first_low = -1;
        for (int i = 0; i < n; i++) begin
            v = use_b ? b_out : a_out;
            if (v) highs++;
            else if (first_low < 0) first_low = i;
            @(negedge clock);
        end
    endtask

    // kind: 0 none expected, 1 applied from OFF, 2 next boundary, 3 after dead-time
    task automatic upd_a(input logic [7:0] r, input logic d, input int kind, output int m);
        int u;
        @(posedge clock); #1;
        a_update = 1'b1; a_ratio = r; a_dir = d;
        u = cyc + 1;
        m = next_boundary(u, e_a, c_PER_A);
        case (kind)
            1: sb.push_back(exp_t'{u + 1, d});
            2: sb.push_back(exp_t'{m, d});
            3: sb.push_back(exp_t'{m + 2 * c_PER_A, d});
            default: ;
        endcase
        @(posedge clock); #1;
        a_update = 1'b0;
    endtask

    task automatic enable_a();
        @(posedge clock); #1;
        a_enable = 1'b1;
        e_a = cyc + 1;
    endtask

    task automatic wait_done_b(input int exp_cyc, input logic exp_dir);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge clock);
            if (b_done) seen = 1'b1;
        end
        check("b_done_seen", int'(seen), 1);
        if (seen) begin
            check("b_done_cycle", cyc, exp_cyc);
            check("b_dir_out", int'(b_dir_out), int'(exp_dir));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int m, h, fl, u, eb, d;

        // Reset state
        @(negedge clock);
        check("rst_pwm_out", int'(a_out), 0);
        check("rst_dir_out", int'(a_dir_out), 0);
        check("rst_done", int'(a_done), 0);
        check("rst_busy", int'(a_busy), 0);
        check("rst_b_busy", int'(b_busy), 0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Ratio 64, dir 0: applied at the next boundary
        enable_a();
        upd_a(8'd64, 1'b0, 2, m);
        check("busy_pending", int'(a_busy), 1);
        wait_cyc(m);
        measure(0, c_PER_A, h, fl);
        check("r64_high", h, 64);
        check("r64_first_low", fl, 64);
        check("r64_busy_idle", int'(a_busy), 0);

        // Ratio 0 then ratio 255
        upd_a(8'd0, 1'b0, 2, m);
        wait_cyc(m);
        measure(0, c_PER_A, h, fl);
        check("r0_high", h, 0);
        upd_a(8'd255, 1'b0, 2, m);
        wait_cyc(m);
        measure(0, 2 * c_PER_A, h, fl);
        check("r255_high", h, 2 * c_PER_A);

        // Three updates within one period: only the last is applied
        upd_a(8'd10, 1'b0, 0, m);
        upd_a(8'd20, 1'b0, 0, m);
        upd_a(8'd30, 1'b0, 2, m);
        wait_cyc(m);
        measure(0, c_PER_A, h, fl);
        check("coalesce_high", h, 30);
        check("coalesce_first_low", fl, 30);

        // Update on the boundary edge itself takes effect at that boundary
        wait_cyc(m + 2 * c_PER_A - 2);
        upd_a(8'd200, 1'b0, 2, m);
        wait_cyc(m);
        measure(0, c_PER_A, h, fl);
        check("bypass_high", h, 200);

        // Direction reversal with two dead periods
        upd_a(8'd128, 1'b0, 2, m);
        wait_cyc(m);
        measure(0, c_PER_A, h, fl);
        check("r128_high", h, 128);
        upd_a(8'd100, 1'b1, 3, m);
        wait_cyc(m);
        measure(0, 300, h, fl);
        check("dead_low_a", h, 0);
        check("dead_busy", int'(a_busy), 1);
        check("dead_dir_hold", int'(a_dir_out), 0);
        measure(0, 2 * c_PER_A - 300, h, fl);
        check("dead_low_b", h, 0);
        measure(0, c_PER_A, h, fl);
        check("rev_high", h, 100);
        check("rev_first_low", fl, 100);
        check("rev_dir", int'(a_dir_out), 1);

        // Disabled: update applied next cycle, output stays low
        @(posedge clock); #1;
        a_enable = 1'b0;
        d = cyc + 1;
        wait_cyc(d);
        check("off_pwm_out", int'(a_out), 0);
        upd_a(8'd50, 1'b1, 1, m);
        @(negedge clock);
        measure(0, 20, h, fl);
        check("off_high", h, 0);
        enable_a();
        wait_cyc(e_a);
        measure(0, c_PER_A, h, fl);
        check("reen_high", h, 50);
        check("reen_first_low", fl, 50);

        // Reset in the middle of dead-time
        upd_a(8'd80, 1'b0, 0, m);
        wait_cyc(m + 100);
        check("pre_rst_busy", int'(a_busy), 1);
        check("pre_rst_dir", int'(a_dir_out), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_pwm_out", int'(a_out), 0);
        check("mid_rst_dir", int'(a_dir_out), 0);
        check("mid_rst_busy", int'(a_busy), 0);
        check("mid_rst_done", int'(a_done), 0);
        a_enable = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        measure(0, 10, h, fl);
        check("post_rst_high", h, 0);
        check("post_rst_dir", int'(a_dir_out), 0);
        check("post_rst_busy", int'(a_busy), 0);
        enable_a();
        wait_cyc(e_a);
        measure(0, c_PER_A, h, fl);
        check("post_rst_ratio0", h, 0);

        // Instance B: CLK_DIV=3, no dead-time
        @(posedge clock); #1;
        b_update = 1'b1; b_ratio = 8'd2; b_dir = 1'b0;
        u = cyc + 1;
        @(posedge clock); #1;
        b_update = 1'b0;
        wait_done_b(u + 1, 1'b0);
        @(posedge clock); #1;
        b_enable = 1'b1;
        eb = cyc + 1;
        wait_cyc(eb);
        measure(1, c_PER_B, h, fl);
        check("b_r2_high", h, 6);
        check("b_r2_first_low", fl, 6);
        @(posedge clock); #1;
        b_update = 1'b1; b_ratio = 8'd1; b_dir = 1'b1;
        u = cyc + 1;
        @(posedge clock); #1;
        b_update = 1'b0;
        m = next_boundary(u, eb, c_PER_B);
        wait_done_b(m, 1'b1);
        measure(1, c_PER_B, h, fl);
        check("b_r1_high", h, 3);
        check("b_r1_first_low", fl, 3);

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
